// File: rtl/rsp_demux2_if.sv
// Signal bundle for the two-way response demultiplexer: one upstream
// valid/ready port and two downstream channels with occupancy counts.
interface rsp_demux2_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              i_in_valid;
  logic              i_in_sel;
  logic [DATA_W-1:0] i_in_data;
  logic              o_in_ready;

  logic              o_out0_valid;
  logic [DATA_W-1:0] o_out0_data;
  logic              i_out0_ready;

  logic              o_out1_valid;
  logic [DATA_W-1:0] o_out1_data;
  logic              i_out1_ready;

  logic [CNT_W-1:0]  o_cnt0;
  logic [CNT_W-1:0]  o_cnt1;

  // Demultiplexer side
  modport slave (
    input  i_in_valid, i_in_sel, i_in_data, i_out0_ready, i_out1_ready,
    output o_in_ready, o_out0_valid, o_out0_data, o_out1_valid, o_out1_data,
    output o_cnt0, o_cnt1
  );

  // Producer/consumer side
  modport master (
    output i_in_valid, i_in_sel, i_in_data, i_out0_ready, i_out1_ready,
    input  o_in_ready, o_out0_valid, o_out0_data, o_out1_valid, o_out1_data,
    input  o_cnt0, o_cnt1
  );
endinterface

// File: rtl/rsp_demux2.sv
// Routes an upstream word stream into one of two independent circular FIFOs
// selected per word; each channel drains through its own valid/ready port.
module rsp_demux2 #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  rsp_demux2_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [1:0]        out_ready;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic [1:0]        full;
  logic [1:0]        nonempty;
  logic [DATA_W-1:0] head_data [2];
  logic [CW-1:0]     cnt       [2];
  logic              in_ready;

  assign out_ready = {bus.i_out1_ready, bus.i_out0_ready};

  // Only the selected queue's fullness gates upstream; no bypass on a same-cycle pop.
  assign in_ready  = ~full[bus.i_in_sel];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [AW-1:0]     wptr_q, wptr_d;
      logic [AW-1:0]     rptr_q, rptr_d;
      logic [CW-1:0]     cnt_q,  cnt_d;
      logic [DATA_W-1:0] mem_q [DEPTH];

      assign full[gi]     = (cnt_q == CNT_FULL);
      assign nonempty[gi] = (cnt_q != '0);
      assign push[gi]     = bus.i_in_valid & in_ready & (bus.i_in_sel == 1'(gi)) & ~i_rst;
      assign pop[gi]      = nonempty[gi] & out_ready[gi];

      always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push[gi]) begin
          wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
        end
        if (pop[gi]) begin
          rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
        end
        case ({push[gi], pop[gi]})
          2'b10:   cnt_d = cnt_q + 1'b1;
          2'b01:   cnt_d = cnt_q - 1'b1;
          default: cnt_d = cnt_q;
        endcase
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          wptr_q <= '0;
          rptr_q <= '0;
          cnt_q  <= '0;
        end else begin
          wptr_q <= wptr_d;
          rptr_q <= rptr_d;
          cnt_q  <= cnt_d;
        end
      end

      // Storage needs no reset: an empty queue masks its head to zero.
      always_ff @(posedge i_clk) begin
        if (push[gi]) begin
          mem_q[wptr_q] <= bus.i_in_data;
        end
      end

      assign head_data[gi] = nonempty[gi] ? mem_q[rptr_q] : '0;
      assign cnt[gi]       = cnt_q;
    end
  endgenerate

  assign bus.o_in_ready   = in_ready;
  assign bus.o_out0_valid = nonempty[0];
  assign bus.o_out0_data  = head_data[0];
  assign bus.o_out1_valid = nonempty[1];
  assign bus.o_out1_data  = head_data[1];
  assign bus.o_cnt0       = cnt[0];
  assign bus.o_cnt1       = cnt[1];
endmodule
